control_unit: RTL
=================

# control_unit

Multi-cycle fetch/decode/execute controller for the 8-bit CPU. It sits directly upstream of the register file and drives that file's write port, both read-address ports and its PC-increment strobe. It reads the PC value back from the register file. It fetches instruction bytes over a req/ack instruction-memory handshake, decodes them, runs a combinational ALU and writes results back.

## Interface
- No parameters; data width fixed at 8, register address width at 2.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  8  fetch address; equals pc_in while imem_req=1.
- imem_ack  in  1  fetch complete; imem_data valid in the same cycle.
- imem_data  in  8  instruction or immediate byte.
- pc_in  in  8  current PC from the register file.
- rf_read_addr1  out  2  register-file read port 1 address (rd).
- rf_read_addr2  out  2  register-file read port 2 address (rs).
- rf_read_data1  in  8  register-file read port 1 data (asynchronous read).
- rf_read_data2  in  8  register-file read port 2 data (asynchronous read).
- rf_write_enable  out  1  register write strobe.
- rf_write_addr  out  2  register write address.
- rf_write_data  out  8  register write data.
- pc_write_enable  out  1  one-cycle PC increment strobe.
- zero_flag  out  1  last ALU result was 0x00.
- carry_flag  out  1  ADD carry-out / SUB borrow.
- halted  out  1  HLT executed.

## Operation
- Instruction byte format: [7:4] opcode, [3:2] rd, [1:0] rs.
- Opcodes:
  - 0 NOP.
  - 1 ADD: rd=rd+rs.
  - 2 SUB: rd=rd-rs.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 MOV: rd=rs.
  - 7 LDI: rd=next byte.
  - 8 HLT.
  - 9–F are treated as NOP.
- States: IDLE, FETCH, DECODE, EXECUTE, FETCH_IMM, WRITEBACK, HALT.
- State transitions:
  - IDLE→FETCH unconditionally.
  - FETCH: imem_req=1. On imem_ack, latch imem_data into IR, pulse pc_write_enable and go to DECODE.
  - DECODE: HLT→HALT; LDI→FETCH_IMM; opcodes 1–6→EXECUTE; all others→FETCH.
  - EXECUTE: rf_read_addr1=rd, rf_read_addr2=rs, rf_write_enable=1, rf_write_addr=rd, rf_write_data=ALU result; then →FETCH.
  - FETCH_IMM: imem_req=1. On imem_ack, latch the immediate into IMM, pulse pc_write_enable and go to WRITEBACK.
  - WRITEBACK: rf_write_enable=1, rf_write_addr=rd, rf_write_data=IMM; then →FETCH.
  - HALT: halted=1; the block stays in HALT until reset.
- ALU arithmetic:
  - All results are 8-bit and wrap modulo 256.
  - ADD: carry = bit 8 of the 9-bit sum.
  - SUB: carry = 1 when rd < rs (unsigned borrow).
- Flag updates:
  - zero_flag and carry_flag update at the end of EXECUTE, for opcodes 1–5 only.
  - AND/OR/XOR clear carry.
  - MOV, LDI and NOP leave both flags unchanged.
- Handshake rules:
  - imem_ack is ignored while imem_req=0.
  - imem_req stays high until ack arrives; there is no timeout.
  - imem_req drops in the cycle after ack.
- pc_write_enable = (FETCH or FETCH_IMM) and imem_ack. It is combinational (Mealy) and exactly one cycle per fetched byte.
- PC wrap: the register file wraps 0xFF→0x00; this block does not treat the wrap specially.

## Timing
- Reset values: every output is 0, the state is IDLE, and IR, IMM and both flags are 0.
- The first imem_req appears in the second cycle after reset deassertion.
- Zero-wait-state memory (ack in the same cycle as req):
  - ALU or MOV instruction: 3 cycles (FETCH, DECODE, EXECUTE).
  - LDI: 4 cycles.
  - NOP or illegal opcode: 2 cycles.
- Each memory wait cycle adds one cycle to its FETCH or FETCH_IMM.
- The register write lands on the clock edge that ends EXECUTE or WRITEBACK. The next FETCH therefore sees the updated registers and the incremented PC.
- Reset asserted mid-operation: outputs go to 0 immediately (asynchronous), any pending fetch or write is abandoned, and the state becomes IDLE.

## Configuration
- CU_IMM_EN:
  - Defined: LDI performs the FETCH_IMM/WRITEBACK sequence described above.
  - Undefined: opcode 7 decodes as NOP (2 cycles, no second fetch). FETCH_IMM, WRITEBACK and IMM are not compiled in.

## Structure
- Package cpu_pkg holds the opcode constants (OP_NOP … OP_HLT) and the state encoding typedef/localparams, shared with the assembler testbench.
- Sub-module alu8: purely combinational. Inputs a, b, op; outputs result, carry, zero.
- control_unit itself holds the FSM, IR, IMM and the flag registers.

## Test plan
All scenarios run against a reset register file.

- Program 0x74,0x05 (LDI R1,5) → 4 cycles; R1=0x05; two pc_write_enable pulses; PC=0x02.
- Then 0x78,0x03 (LDI R2,3), then 0x16 (ADD R1,R2) → R1=0x08, zero=0, carry=0, PC=0x05.
- Then 0x21 (SUB R0,R1) with R0=0 → R0=0xF8, carry=1, zero=0.
- Then 0x35 (AND R1,R1) → carry cleared. Then 0x55 (XOR R1,R1) → R1=0x00, zero=1, carry=0.
- Memory ack delayed 3 cycles on each fetch → imem_addr stable and imem_req held throughout the wait, one pc_write_enable per byte, results identical to the zero-wait runs.
- Byte 0x80 (HLT) → halted=1 from the cycle after DECODE, imem_req stays 0 indefinitely. Reset asserted mid-FETCH → all outputs 0 immediately; after deassertion, the fetch restarts from PC 0x00.
- With CU_IMM_EN undefined, byte 0x74 → 2 cycles, no register write, PC +1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcode constants, controller state encoding
// and small decode helpers.
package cpu_pkg;

  localparam int unsigned DataW    = 8;
  localparam int unsigned RegAddrW = 2;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_HLT = 4'h8;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StFetchImm,
    StWriteback,
    StHalt
  } state_e;

  // Opcodes whose result updates zero/carry.
  function automatic logic is_flag_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  // Opcodes that pass through EXECUTE and write rd.
  function automatic logic is_exec_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/alu8.sv
// alu8: purely combinational 8-bit ALU for the control unit; carry is the ADD carry-out
// or the SUB borrow, and is 0 for every other opcode.
module alu8
  import cpu_pkg::*;
(
  input  logic [DataW-1:0] a,
  input  logic [DataW-1:0] b,
  input  logic [3:0]       op,
  output logic [DataW-1:0] result,
  output logic             carry,
  output logic             zero
);

  logic [DataW:0] w_sum;

  always_comb begin
    w_sum  = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        w_sum  = {1'b0, a} + {1'b0, b};
        result = w_sum[DataW-1:0];
        carry  = w_sum[DataW];
      end
      // A 9-bit subtract leaves the unsigned borrow in the top bit.
      OP_SUB: begin
        w_sum  = {1'b0, a} - {1'b0, b};
        result = w_sum[DataW-1:0];
        carry  = w_sum[DataW];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute controller driving the register file.
// Define CU_IMM_EN to build LDI with its immediate fetch; otherwise opcode 7 is a NOP.
module control_unit
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [DataW-1:0]    imem_addr,
  input  logic                imem_ack,
  input  logic [DataW-1:0]    imem_data,
  input  logic [DataW-1:0]    pc_in,
  output logic [RegAddrW-1:0] rf_read_addr1,
  output logic [RegAddrW-1:0] rf_read_addr2,
  input  logic [DataW-1:0]    rf_read_data1,
  input  logic [DataW-1:0]    rf_read_data2,
  output logic                rf_write_enable,
  output logic [RegAddrW-1:0] rf_write_addr,
  output logic [DataW-1:0]    rf_write_data,
  output logic                pc_write_enable,
  output logic                zero_flag,
  output logic                carry_flag,
  output logic                halted
);

  state_e              r_state;
  state_e              w_state_next;
  logic [DataW-1:0]    r_ir;
`ifdef CU_IMM_EN
  logic [DataW-1:0]    r_imm;
`endif
  logic                r_zero;
  logic                r_carry;

  logic [3:0]          w_op;
  logic [RegAddrW-1:0] w_rd;
  logic [RegAddrW-1:0] w_rs;
  logic [DataW-1:0]    w_alu_result;
  logic                w_alu_carry;
  logic                w_alu_zero;

  assign w_op = r_ir[7:4];
  assign w_rd = r_ir[3:2];
  assign w_rs = r_ir[1:0];

  alu8 u_alu (
    .a      (rf_read_data1),
    .b      (rf_read_data2),
    .op     (w_op),
    .result (w_alu_result),
    .carry  (w_alu_carry),
    .zero   (w_alu_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_ir    <= '0;
`ifdef CU_IMM_EN
      r_imm   <= '0;
`endif
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == StFetch) && imem_ack) begin
        r_ir <= imem_data;
      end
`ifdef CU_IMM_EN
      if ((r_state == StFetchImm) && imem_ack) begin
        r_imm <= imem_data;
      end
`endif
      if ((r_state == StExecute) && is_flag_op(w_op)) begin
        r_zero  <= w_alu_zero;
        r_carry <= w_alu_carry;
      end
    end
  end

  // All outputs decode from the state register, so an asynchronous reset clears them at once.
  always_comb begin
    w_state_next    = r_state;
    imem_req        = 1'b0;
    imem_addr       = '0;
    pc_write_enable = 1'b0;
    rf_read_addr1   = '0;
    rf_read_addr2   = '0;
    rf_write_enable = 1'b0;
    rf_write_addr   = '0;
    rf_write_data   = '0;
    halted          = 1'b0;
    unique case (r_state)
      StIdle: w_state_next = StFetch;
      StFetch: begin
        imem_req  = 1'b1;
        imem_addr = pc_in;
        if (imem_ack) begin
          pc_write_enable = 1'b1;
          w_state_next    = StDecode;
        end
      end
      StDecode: begin
        if (w_op == OP_HLT) begin
          w_state_next = StHalt;
`ifdef CU_IMM_EN
        end else if (w_op == OP_LDI) begin
          w_state_next = StFetchImm;
`endif
        end else if (is_exec_op(w_op)) begin
          w_state_next = StExecute;
        end else begin
          w_state_next = StFetch;
        end
      end
      StExecute: begin
        rf_read_addr1   = w_rd;
        rf_read_addr2   = w_rs;
        rf_write_enable = 1'b1;
        rf_write_addr   = w_rd;
        rf_write_data   = w_alu_result;
        w_state_next    = StFetch;
      end
`ifdef CU_IMM_EN
      StFetchImm: begin
        imem_req  = 1'b1;
        imem_addr = pc_in;
        if (imem_ack) begin
          pc_write_enable = 1'b1;
          w_state_next    = StWriteback;
        end
      end
      StWriteback: begin
        rf_write_enable = 1'b1;
        rf_write_addr   = w_rd;
        rf_write_data   = r_imm;
        w_state_next    = StFetch;
      end
`endif
      StHalt: halted = 1'b1;
      default: w_state_next = StIdle;
    endcase
  end

  assign zero_flag  = r_zero;
  assign carry_flag = r_carry;

endmodule
